// File: rtl/alu_ctrl.sv
// Two-requester command front end for an external combinational ALU: round-robin
// grant, one command in flight, registered response. Optional ALU_CTRL_ILLEGAL_OP_CHECK_EN.
module alu_ctrl #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_rdo,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdo,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              prio;  // 1: requester 1 wins a tie
  logic [1:0]        grant;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic              illegal;

  always_comb begin
    grant = 2'b00;
    if (!rst && state == IDLE) begin
      if (req_valid[1] && (!req_valid[0] || prio)) grant = 2'b10;
      else if (req_valid[0])                       grant = 2'b01;
    end
  end

  assign req_ready = grant;
  assign sel_a     = grant[1] ? req1_a  : req0_a;
  assign sel_b     = grant[1] ? req1_b  : req0_b;
  assign sel_op    = grant[1] ? req1_op : req0_op;

`ifdef ALU_CTRL_ILLEGAL_OP_CHECK_EN
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(6'b000010);

  always_comb begin
    case (sel_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: illegal = 1'b0;
      default:                                                      illegal = 1'b1;
    endcase
  end

  // Error flag only changes at a grant, so it stays stable through RESP.
  always_ff @(posedge clk) begin
    if (rst)                          rsp_err <= 1'b0;
    else if (state == IDLE && |grant) rsp_err <= illegal;
  end
`else
  assign illegal = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdo   <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      op_count  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            rsp_id <= grant[1];
            prio   <= grant[0];
            if (illegal) begin
              rsp_rdo   <= '0;
              rsp_carry <= 1'b0;
              rsp_zero  <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_rdo   <= alu_rdo;
          rsp_carry <= alu_carry;
          rsp_zero  <= alu_zero;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
